// File: rtl/counter_updown_mod.sv
// Parametrised synchronous up/down counter with parallel load, cascade enables (enp/ent/rco)
// and a sticky wrap flag that has its own clear.
module counter_updown_mod #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned MAX   = 2**WIDTH - 1
) (
    input  logic             i_clk,
    input  logic             i_clr,
    input  logic             i_load,
    input  logic [WIDTH-1:0] i_d,
    input  logic             i_enp,
    input  logic             i_ent,
    input  logic             i_up,
    input  logic             i_ovf_clr,
    output logic [WIDTH-1:0] o_q,
    output logic             o_rco,
    output logic             o_ovf
);

    localparam logic [WIDTH-1:0] MaxVal = WIDTH'(MAX);

    logic [WIDTH-1:0] r_q;
    logic             r_ovf;
    logic             w_tc;
    logic             w_count;
    logic [WIDTH-1:0] w_q_step;

    // Up uses >= so a value loaded above MAX still wraps to 0 on the next up count.
    assign w_tc    = i_up ? (r_q >= MaxVal) : (r_q == '0);
    assign w_count = i_enp & i_ent;

    always_comb begin
        w_q_step = r_q;
        if (i_up) begin
            w_q_step = w_tc ? '0 : r_q + 1'b1;
        end else begin
            w_q_step = w_tc ? MaxVal : r_q - 1'b1;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_clr) begin
            r_q   <= '0;
            r_ovf <= 1'b0;
        end else begin
            if (i_load) begin
                r_q <= i_d;
            end else if (w_count) begin
                r_q <= w_q_step;
            end
            // A wrap beats a coincident flag clear.
            if (!i_load && w_count && w_tc) begin
                r_ovf <= 1'b1;
            end else if (i_ovf_clr) begin
                r_ovf <= 1'b0;
            end
        end
    end

    assign o_q   = r_q;
    assign o_rco = i_ent & w_tc;
    assign o_ovf = r_ovf;

endmodule

// File: tb/tb_counter_updown_mod.sv
// Scoreboard bench: stimulus pushes hand-computed expected outputs, a monitor pops and compares.
module tb_counter_updown_mod;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string      name;
        int         unit;
        logic [7:0] q;
        logic       rco;
        logic       ovf;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_errors = 0;

    // Unit 0: WIDTH=4 MAX=9; unit 1: WIDTH=4 MAX=15; unit 2: two-stage cascade (unit 3 = low stage).
    logic [2:0] s_clr, s_load, s_enp, s_ent, s_up, s_oc;
    logic [7:0] s_d [3];

    logic [3:0] a_q, b_q, lo_q, hi_q;
    logic       a_rco, a_ovf, b_rco, b_ovf, lo_rco, lo_ovf, hi_rco, hi_ovf;

    counter_updown_mod #(.WIDTH(4), .MAX(9)) u_a (
        .i_clk(clk), .i_clr(s_clr[0]), .i_load(s_load[0]), .i_d(s_d[0][3:0]),
        .i_enp(s_enp[0]), .i_ent(s_ent[0]), .i_up(s_up[0]), .i_ovf_clr(s_oc[0]),
        .o_q(a_q), .o_rco(a_rco), .o_ovf(a_ovf)
    );

    counter_updown_mod #(.WIDTH(4), .MAX(15)) u_b (
        .i_clk(clk), .i_clr(s_clr[1]), .i_load(s_load[1]), .i_d(s_d[1][3:0]),
        .i_enp(s_enp[1]), .i_ent(s_ent[1]), .i_up(s_up[1]), .i_ovf_clr(s_oc[1]),
        .o_q(b_q), .o_rco(b_rco), .o_ovf(b_ovf)
    );

    counter_updown_mod #(.WIDTH(4), .MAX(15)) u_lo (
        .i_clk(clk), .i_clr(s_clr[2]), .i_load(s_load[2]), .i_d(s_d[2][3:0]),
        .i_enp(s_enp[2]), .i_ent(s_ent[2]), .i_up(s_up[2]), .i_ovf_clr(s_oc[2]),
        .o_q(lo_q), .o_rco(lo_rco), .o_ovf(lo_ovf)
    );

    counter_updown_mod #(.WIDTH(4), .MAX(15)) u_hi (
        .i_clk(clk), .i_clr(s_clr[2]), .i_load(s_load[2]), .i_d(s_d[2][7:4]),
        .i_enp(s_enp[2]), .i_ent(lo_rco), .i_up(s_up[2]), .i_ovf_clr(s_oc[2]),
        .o_q(hi_q), .o_rco(hi_rco), .o_ovf(hi_ovf)
    );

    // Apply inputs at a falling edge; expected values describe the outputs seen now,
    // i.e. state from the previous rising edge combined with these inputs.
    task automatic step(input int unit, input logic clr, input logic load, input logic [7:0] d,
                        input logic enp, input logic ent, input logic up, input logic oc,
                        input string name, input logic [7:0] eq, input logic erco,
                        input logic eovf);
        exp_t e;
        @(negedge clk);
        s_clr[unit]  = clr;
        s_load[unit] = load;
        s_d[unit]    = d;
        s_enp[unit]  = enp;
        s_ent[unit]  = ent;
        s_up[unit]   = up;
        s_oc[unit]   = oc;
        e.name = name;
        e.unit = unit;
        e.q    = eq;
        e.rco  = erco;
        e.ovf  = eovf;
        sb.push_back(e);
    endtask

    // Monitor
    initial begin
        exp_t       e;
        logic [7:0] aq;
        logic       ar, ao;
        forever begin
            @(negedge clk);
            #2;
            while (sb.size() > 0) begin
                e = sb.pop_front();
                case (e.unit)
                    0:       begin aq = {4'h0, a_q};  ar = a_rco;  ao = a_ovf;  end
                    1:       begin aq = {4'h0, b_q};  ar = b_rco;  ao = b_ovf;  end
                    2:       begin aq = {hi_q, lo_q}; ar = hi_rco; ao = hi_ovf; end
                    default: begin aq = {4'h0, lo_q}; ar = lo_rco; ao = lo_ovf; end
                endcase
                n_checks++;
                if (aq !== e.q || ar !== e.rco || ao !== e.ovf) begin
                    n_errors++;
                    $display("FAIL %s: got q=%0h rco=%b ovf=%b, want q=%0h rco=%b ovf=%b",
                             e.name, aq, ar, ao, e.q, e.rco, e.ovf);
                end
            end
        end
    end

    initial begin
        exp_t e;
        s_clr  = '1;
        s_load = '0;
        s_enp  = '0;
        s_ent  = '0;
        s_up   = '0;
        s_oc   = '0;
        foreach (s_d[i]) s_d[i] = 8'h00;
        repeat (2) @(posedge clk);

        // Unit 0, MAX=9: up wrap
        for (int i = 0; i <= 9; i++) step(0, 0, 0, 0, 1, 1, 1, 0, "a_up", 8'(i), i == 9, 0);
        step(0, 0, 0, 0,  1, 1, 1, 0, "a_up_wrap",    0, 0, 1);
        step(0, 0, 0, 0,  0, 1, 1, 0, "a_hold",       1, 0, 1);
        // Flag clear vs coincident wrap
        step(0, 0, 1, 9,  0, 1, 1, 1, "a_sticky",     1, 0, 1);
        step(0, 0, 0, 0,  1, 1, 1, 1, "a_load_no_ovf", 9, 1, 0);
        step(0, 0, 0, 0,  1, 1, 1, 1, "a_set_wins",   0, 0, 1);
        // Down wrap and gating
        step(0, 0, 1, 1,  0, 1, 0, 0, "a_clr_nowrap", 1, 0, 0);
        step(0, 0, 0, 0,  1, 1, 0, 0, "a_dn_1",       1, 0, 0);
        step(0, 0, 0, 0,  1, 1, 0, 0, "a_dn_0",       0, 1, 0);
        step(0, 0, 1, 0,  0, 1, 0, 1, "a_dn_wrap",    9, 0, 1);
        step(0, 0, 0, 0,  1, 0, 0, 0, "a_ld0_no_ovf", 0, 0, 0);
        step(0, 0, 0, 0,  0, 1, 0, 0, "a_ent0_hold",  0, 1, 0);
        step(0, 0, 1, 13, 1, 1, 0, 0, "a_enp0_rco",   0, 1, 0);
        // Out-of-range value 13: down count walks back into range without a wrap
        for (int v = 13; v >= 9; v--) step(0, 0, 0, 0, 1, 1, 0, 0, "a_oor_dn", 8'(v), 0, 0);
        step(0, 0, 1, 13, 0, 0, 1, 0, "a_oor_dn_end", 8, 0, 0);
        step(0, 0, 0, 0,  1, 1, 1, 0, "a_oor_up",     13, 1, 0);
        step(0, 0, 0, 0,  0, 0, 1, 0, "a_oor_up_wrap", 0, 0, 1);

        // Unit 1, MAX=15: reset mid-count overrides load and wrap
        step(1, 0, 1, 15, 0, 0, 1, 0, "b_init",        0, 0, 0);
        step(1, 0, 0, 0,  1, 1, 1, 0, "b_at_max",      15, 1, 0);
        step(1, 0, 1, 6,  1, 1, 1, 0, "b_wrap",        0, 0, 1);
        step(1, 0, 0, 0,  1, 1, 1, 0, "b_count",       6, 0, 1);
        step(1, 1, 1, 9,  1, 1, 1, 0, "b_mid",         7, 0, 1);
        step(1, 0, 1, 15, 0, 0, 1, 0, "b_reset",       0, 0, 0);
        step(1, 1, 0, 0,  1, 1, 1, 0, "b_max_again",   15, 1, 0);
        step(1, 0, 0, 0,  0, 0, 1, 0, "b_clr_vs_wrap", 0, 0, 0);

        // Unit 2: 8-bit cascade from two 4-bit stages
        step(2, 0, 1, 8'h0E, 1, 1, 1, 0, "c_init", 8'h00, 0, 0);
        step(2, 0, 0, 8'h00, 1, 1, 1, 0, "c_0e",   8'h0E, 0, 0);
        step(2, 0, 0, 8'h00, 1, 1, 1, 0, "c_0f",   8'h0F, 0, 0);
        step(2, 0, 1, 8'hFE, 1, 1, 1, 0, "c_10",   8'h10, 0, 0);
        step(2, 0, 0, 8'h00, 1, 1, 1, 0, "c_fe",   8'hFE, 0, 0);
        step(2, 0, 0, 8'h00, 1, 1, 1, 0, "c_ff",   8'hFF, 1, 0);
        step(2, 0, 0, 8'h00, 0, 1, 1, 0, "c_wrap", 8'h00, 0, 1);
        e.name = "c_lo_flag";
        e.unit = 3;
        e.q    = 8'h00;
        e.rco  = 1'b0;
        e.ovf  = 1'b1;
        sb.push_back(e);

        repeat (3) @(posedge clk);
        n_checks++;
        if (sb.size() != 0) begin
            n_errors++;
            $display("FAIL drain: got %0d pending entries, want 0", sb.size());
        end
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
